// File: rtl/multiplier_arbiter.sv
// multiplier_arbiter: round-robin sequencer sharing one signed integer
// multiplier among NUM_REQ requesters. The winner's operands are latched at
// grant, the multiplier is started with a one-cycle pulse, and the product is
// returned with a one-cycle done strobe to the granted requester.
//
// Handshake: req[i] is a level request held until done[i] pulses. mul_start
// is a one-cycle pulse issued on entry to START. mul_ready high means the
// multiplier is idle or holding a valid product. A falling edge of mul_ready
// means the operation was accepted. The next rising edge means mul_product
// is valid.
//
// Optional feature: define MUL_ARB_TIMEOUT_EN to enable a watchdog. It
// completes a stalled operation after TIMEOUT_CYCLES with result=0 and sets
// the sticky error flag.
module multiplier_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REQ        = 4,
  parameter int IDX_W          = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_multiplier,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_multiplicand,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         result,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          busy,
  output logic                          mul_start,
  output logic [DATA_WIDTH-1:0]         mul_multiplier,
  output logic [DATA_WIDTH-1:0]         mul_multiplicand,
  input  logic [DATA_WIDTH-1:0]         mul_product,
  input  logic                          mul_ready,
  output logic                          error
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_LOW  = 3'd2,
    S_WAIT_HIGH = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic             any_req;
  logic [IDX_W-1:0] winner;
  logic             active;
  logic             timeout_hit;

  assign active = (state == S_START) || (state == S_WAIT_LOW) ||
                  (state == S_WAIT_HIGH);

  // Round-robin pick: first set req bit after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    int cand;
    cand    = 0;
    any_req = 1'b0;
    winner  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        winner  = IDX_W'(cand);
      end
    end
  end

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;

  // Fires on the TIMEOUT_CYCLES-th cycle spent waiting on the multiplier
  assign timeout_hit = active && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog counter cleared while idle, plus the sticky error flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      tcnt  <= '0;
      error <= 1'b0;
    end else if (state == S_IDLE) begin
      tcnt <= '0;
    end else if (active) begin
      tcnt <= tcnt + 1'b1;
      if (timeout_hit) error <= 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  // Main sequencer: grant, start pulse, ready handshake, done strobe
  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= S_IDLE;
      rr_ptr           <= IDX_W'(NUM_REQ - 1);
      done             <= '0;
      result           <= '0;
      grant_idx        <= '0;
      busy             <= 1'b0;
      mul_start        <= 1'b0;
      mul_multiplier   <= '0;
      mul_multiplicand <= '0;
    end else begin
      done      <= '0;
      mul_start <= 1'b0;
      if (timeout_hit) begin
        // Stalled multiplier: finish the operation with a zero result
        result <= '0;
        done   <= NUM_REQ'(1) << grant_idx;
        state  <= S_DONE;
      end else begin
        case (state)
          S_IDLE: begin
            if (any_req) begin
              grant_idx        <= winner;
              rr_ptr           <= winner;
              mul_multiplier   <= req_multiplier[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
              mul_multiplicand <= req_multiplicand[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
              busy             <= 1'b1;
              mul_start        <= 1'b1;
              state            <= S_START;
            end
          end
          S_START: begin
            // mul_start is only high on entry; stay here until ready is seen
            if (mul_ready) state <= S_WAIT_LOW;
          end
          S_WAIT_LOW: begin
            if (!mul_ready) state <= S_WAIT_HIGH;
          end
          S_WAIT_HIGH: begin
            if (mul_ready) begin
              result <= mul_product;
              done   <= NUM_REQ'(1) << grant_idx;
              state  <= S_DONE;
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Directed bench for multiplier_arbiter with a small multiplier model.
// Build with MUL_ARB_TIMEOUT_EN defined to also exercise the watchdog.
module tb_multiplier_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int IW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req = '0;
  logic [NR*DW-1:0] req_multiplier = '0;
  logic [NR*DW-1:0] req_multiplicand = '0;
  logic [NR-1:0]    done;
  logic [DW-1:0]    result;
  logic [IW-1:0]    grant_idx;
  logic             busy;
  logic             mul_start;
  logic [DW-1:0]    mul_multiplier;
  logic [DW-1:0]    mul_multiplicand;
  logic [DW-1:0]    mul_product;
  logic             mul_ready;
  logic             error;

  multiplier_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .IDX_W(IW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_multiplier(req_multiplier), .req_multiplicand(req_multiplicand),
    .done(done), .result(result), .grant_idx(grant_idx), .busy(busy),
    .mul_start(mul_start), .mul_multiplier(mul_multiplier),
    .mul_multiplicand(mul_multiplicand), .mul_product(mul_product),
    .mul_ready(mul_ready), .error(error)
  );

  // ---------------- multiplier model (3-cycle compute) ----------------
  logic          model_ready = 1'b1;
  int            model_cnt = 0;
  logic [DW-1:0] model_a = '0;
  logic [DW-1:0] model_b = '0;
  logic [DW-1:0] model_p = '0;
  logic          stuck = 1'b0;

  assign mul_ready   = stuck ? 1'b0 : model_ready;
  assign mul_product = model_p;

  always @(posedge clk) begin
    if (mul_start && mul_ready) begin
      model_ready <= 1'b0;
      model_cnt   <= 3;
      model_a     <= mul_multiplier;
      model_b     <= mul_multiplicand;
    end else if (!model_ready) begin
      if (model_cnt == 0) begin
        model_ready <= 1'b1;
        model_p     <= DW'($signed(model_a) * $signed(model_b));
      end else begin
        model_cnt <= model_cnt - 1;
      end
    end
  end

  // ---------------- observation monitor ----------------
  logic [DW-1:0] obs_idx_q[$];
  logic [DW-1:0] obs_res_q[$];
  int start_cnt  = 0;
  int multi_done = 0;

  always @(posedge clk) begin
    #2;
    if (reset) begin
      if (mul_start) start_cnt++;
      if (done != '0) begin
        if ($countones(done) != 1) multi_done++;
        for (int i = 0; i < NR; i++) begin
          if (done[i]) begin
            obs_idx_q.push_back(DW'(i));
            obs_res_q.push_back(result);
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_done(input string tag, input int exp_idx,
                            input logic [DW-1:0] exp_res);
    logic [DW-1:0] gi;
    logic [DW-1:0] gr;
    gi = 'x;
    gr = 'x;
    if (obs_idx_q.size() > 0) begin
      gi = obs_idx_q.pop_front();
      gr = obs_res_q.pop_front();
    end
    check({tag, "_idx"}, gi, DW'(exp_idx));
    check({tag, "_res"}, gr, exp_res);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    obs_idx_q.delete();
    obs_res_q.delete();
    start_cnt  = 0;
    multi_done = 0;
  endtask

  task automatic set_ops(input int i, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
    req_multiplier[i*DW +: DW]   = a;
    req_multiplicand[i*DW +: DW] = b;
  endtask

  // Wait until n done strobes were seen; optionally drop each finished req
  task automatic wait_dones(input int n, input bit drop);
    int t;
    t = 0;
    while (obs_res_q.size() < n && t < 300) begin
      @(negedge clk);
      t++;
      if (drop) req = req & ~done;
    end
    check("wait_done", DW'(obs_res_q.size()), DW'(n));
  endtask

  // Wait until the multiplier has accepted (ready low), then one more cycle
  task automatic wait_in_wait_high();
    int t;
    t = 0;
    while (mul_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("accept_seen", DW'(mul_ready), DW'(0));
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_done", DW'(done), 0);
    check("rst_result", result, 0);
    check("rst_grant", DW'(grant_idx), 0);
    check("rst_busy", DW'(busy), 0);
    check("rst_start", DW'(mul_start), 0);
    check("rst_mplier", mul_multiplier, 0);
    check("rst_mcand", mul_multiplicand, 0);
    check("rst_error", DW'(error), 0);
    reset = 1'b1;

    // Single request: 7 * -6 = -42
    set_ops(0, 32'd7, 32'hFFFF_FFFA);
    req = 4'b0001;
    wait_dones(1, 1'b1);
    check_done("single", 0, 32'hFFFF_FFD6);
    repeat (2) @(negedge clk);
    check("single_starts", DW'(start_cnt), 1);
    check("single_busy_after", DW'(busy), 0);

    // All four requesting: order 0,1,2,3
    do_reset();
    for (int i = 0; i < NR; i++) set_ops(i, DW'(i + 1), 32'd10);
    req = 4'b1111;
    wait_dones(4, 1'b1);
    check_done("all0", 0, 32'd10);
    check_done("all1", 1, 32'd20);
    check_done("all2", 2, 32'd30);
    check_done("all3", 3, 32'd40);
    check("all_one_hot", DW'(multi_done), 0);
    check("all_starts", DW'(start_cnt), 4);

    // Fairness: req0 held, req2 raised after first grant -> 0,2,0,2
    do_reset();
    set_ops(0, 32'd2, 32'd3);
    set_ops(2, 32'hFFFF_FFFC, 32'd5);
    req = 4'b0001;
    cyc = 0;
    while (!busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    req[2] = 1'b1;
    wait_dones(4, 1'b0);
    req = '0;
    check_done("rr0", 0, 32'd6);
    check_done("rr1", 2, 32'hFFFF_FFEC);
    check_done("rr2", 0, 32'd6);
    check_done("rr3", 2, 32'hFFFF_FFEC);

    // Operand stability: operand changes after grant are ignored
    do_reset();
    set_ops(1, 32'd3, 32'd5);
    req = 4'b0010;
    wait_in_wait_high();
    req_multiplier[1*DW +: DW] = 32'd99;
    check("stable_mplier", mul_multiplier, 32'd3);
    wait_dones(1, 1'b1);
    check_done("stable", 1, 32'd15);
    check("stable_grant", DW'(grant_idx), 1);

    // Reset during WAIT_HIGH aborts silently
    do_reset();
    set_ops(0, 32'd4, 32'd4);
    req = 4'b0001;
    wait_in_wait_high();
    reset = 1'b0;
    req   = '0;
    @(negedge clk);
    check("abort_busy", DW'(busy), 0);
    check("abort_done", DW'(done), 0);
    check("abort_result", result, 0);
    check("abort_grant", DW'(grant_idx), 0);
    check("abort_start", DW'(mul_start), 0);
    check("abort_mplier", mul_multiplier, 0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_done", DW'(obs_res_q.size()), 0);
    set_ops(0, 32'hFFFF_FFFD, 32'hFFFF_FFFD);
    set_ops(2, 32'd1, 32'd8);
    req = 4'b0101;
    wait_dones(2, 1'b1);
    check_done("post_abort0", 0, 32'd9);
    check_done("post_abort1", 2, 32'd8);

`ifdef MUL_ARB_TIMEOUT_EN
    // Watchdog: multiplier never ready, completes after about 16 cycles
    do_reset();
    stuck = 1'b1;
    set_ops(0, 32'd2, 32'd2);
    req = 4'b0001;
    cyc = 0;
    while (!busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    cyc = 0;
    while (done == '0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    req = '0;
    check("to_latency_ok", DW'(cyc >= 15 && cyc <= 17), 1);
    @(negedge clk);
    check_done("timeout", 0, 32'd0);
    check("to_error", DW'(error), 1);
    stuck = 1'b0;
    repeat (2) @(negedge clk);
    set_ops(1, 32'd6, 32'd7);
    req = 4'b0010;
    wait_dones(1, 1'b1);
    check_done("after_to", 1, 32'd42);
    check("to_error_sticky", DW'(error), 1);
`else
    check("error_tied_low", DW'(error), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound
  initial begin
    #400000;
    $display("FAIL watchdog: bench did not complete, observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/multiplier_arbiter.md
Name: multiplier_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one 32-bit signed integer multiplier (start/ready handshake, product held valid while ready high) among NUM_REQ requesters.
- Latches the winner's operands and pulses the multiplier start.
- Tracks the ready handshake and returns the product with a one-cycle done strobe to the winning requester.
- Sits between accelerator processing elements and the integer multiplier wrapper.

Parameters:
- DATA_WIDTH, 32, operand/product width
- NUM_REQ, 4, number of requesters (2..16)
- IDX_W, 2, width of grant index, must equal ceil(log2(NUM_REQ))
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset (sampled on clk; 0 = reset)
- req  in  NUM_REQ  per-requester level request; held high until done
- req_multiplier  in  NUM_REQ*DATA_WIDTH  packed operands, slice i = requester i
- req_multiplicand  in  NUM_REQ*DATA_WIDTH  packed operands, slice i = requester i
- done  out  NUM_REQ  one-hot, one-cycle completion strobe
- result  out  DATA_WIDTH  signed product, valid in done cycle, held until next done
- grant_idx  out  IDX_W  index of current/last granted requester
- busy  out  1  high from grant until done (inclusive)
- mul_start  out  1  to multiplier start
- mul_multiplier  out  DATA_WIDTH  to multiplier operand
- mul_multiplicand  out  DATA_WIDTH  to multiplier operand
- mul_product  in  DATA_WIDTH  from multiplier product
- mul_ready  in  1  from multiplier ready (level: high = idle/result valid)
- error  out  1  sticky timeout flag (0 when feature compiled out)

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; done=0, result=0, grant_idx=0, busy=0, mul_start=0, mul operand regs=0, error=0.
  - RR pointer=NUM_REQ-1, so requester 0 wins first.
  - Reset mid-operation aborts silently: no done is issued; multiplier output is ignored until the next grant.
- IDLE:
  - If any req bit is high, choose the first set bit searching from pointer+1 upward, wrapping modulo NUM_REQ.
  - Register grant_idx, pointer=winner, and latch the winner's operand slices into mul_multiplier/mul_multiplicand.
  - busy=1; go to START.
- START:
  - mul_start=1 for exactly this cycle; operands stable.
  - If mul_ready==1, go to WAIT_LOW; if mul_ready==0, wait here holding mul_start low after the first cycle (START re-asserts only on entry).
- WAIT_LOW: stay until mul_ready==0 (multiplier accepted), then go to WAIT_HIGH.
- WAIT_HIGH: stay until mul_ready==1, then latch result=mul_product and go to DONE.
- DONE:
  - done[grant_idx]=1 for one cycle; busy=1 this cycle.
  - Next state IDLE with busy=0.
  - Earliest re-arbitration is the cycle after DONE.
- Minimum latency from req rise to done = 4 cycles plus multiplier compute time.
- Operands are latched at grant; later changes on req_* are ignored.
- A requester dropping req mid-operation: the operation completes and its done still pulses.
- Simultaneous requests are served in RR order. With all req high, the grant sequence is 0,1,2,3,0…
- No requester waits more than NUM_REQ-1 other operations.
- A requester that keeps req high after done re-competes. It wins back-to-back only if no other req is set.
- Arithmetic is performed entirely by the multiplier; the block passes mul_product unmodified (signed, low DATA_WIDTH bits).

Optional Feature:
- Macro: MUL_ARB_TIMEOUT_EN.
- With the macro: a counter runs in START/WAIT_LOW/WAIT_HIGH and clears on grant.
  - When it reaches TIMEOUT_CYCLES, error is set (sticky until reset), result=0, and done[grant_idx] pulses.
  - The FSM returns to IDLE and the RR pointer advances normally.
- Without the macro: no counter; error is tied 0; the FSM waits indefinitely on mul_ready.

Test Plan:
- Single request: reset low 3 cycles; req=0001, operands 7 and -6. Expected: one mul_start pulse, done=0001 once, result=-42 (0xFFFFFFD6), busy low afterward.
- All four req high simultaneously, operands i+1 and 10. Expected: done order 0,1,2,3 with results 10,20,30,40; no two done in the same cycle.
- Round-robin fairness: req0 held continuously with req2 toggled on after the first grant. Expected: grants 0,2,0,2; req0 is never granted twice while req2 is pending.
- Operand stability: change req_multiplier of the granted requester to 99 in WAIT_HIGH. Expected: mul_multiplier unchanged and result uses the latched value (e.g. 3*5=15).
- Reset mid-operation: assert reset low during WAIT_HIGH. Expected: all outputs 0 next cycle, no done pulse, and the next request is granted to requester 0.
- With MUL_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, model multiplier with mul_ready stuck low. Expected: done pulses with result=0 and error=1 about 16 cycles after grant; a subsequent normal op completes correctly and error stays 1.
